// File: rtl/kypd_entry_if.sv
// Keypad entry bus: raw scanner inputs toward the entry block and the
// debounced key / assembled entry results back out to display and consumers.
interface kypd_entry_if;
    logic [3:0]  key_raw;
    logic        key_hit;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] entry;
    logic [2:0]  digit_count;
    logic [15:0] entry_value;
    logic        entry_done;
    logic        overflow;

    // Scanner / stimulus side: drives raw inputs, observes results.
    modport master (
        output key_raw, key_hit,
        input  key_code, key_valid, entry, digit_count,
               entry_value, entry_done, overflow
    );

    // Entry block side.
    modport slave (
        input  key_raw, key_hit,
        output key_code, key_valid, entry, digit_count,
               entry_value, entry_done, overflow
    );
endinterface

// File: rtl/kypd_entry.sv
// Keypad entry: debounces the scanner's raw key code and hit flag, emits one
// event per physical press and assembles up to four hex digits with clear
// (0xE) and enter (0xF) handling.
module kypd_entry #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic          clk,
    input  logic          reset,
    kypd_entry_if.slave   kp
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [3:0]         code_reg, code_next;
    logic               accept;

    logic [3:0]         key_code_reg, key_code_next;
    logic               key_valid_reg, key_valid_next;
    logic [15:0]        entry_reg, entry_next;
    logic [2:0]         count_reg, count_next;
    logic [15:0]        entry_value_reg, entry_value_next;
    logic               entry_done_reg, entry_done_next;
    logic               overflow_reg, overflow_next;

    // Entry shifted left by one digit with the captured code as newest nibble.
    logic [15:0]        entry_shifted;

    assign entry_shifted[3:0] = code_reg;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_shift
            assign entry_shifted[gi*4 +: 4] = entry_reg[(gi-1)*4 +: 4];
        end
    endgenerate

    // State, debounce counter, captured code and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            code_reg        <= '0;
            key_code_reg    <= '0;
            key_valid_reg   <= 1'b0;
            entry_reg       <= '0;
            count_reg       <= '0;
            entry_value_reg <= '0;
            entry_done_reg  <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            code_reg        <= code_next;
            key_code_reg    <= key_code_next;
            key_valid_reg   <= key_valid_next;
            entry_reg       <= entry_next;
            count_reg       <= count_next;
            entry_value_reg <= entry_value_next;
            entry_done_reg  <= entry_done_next;
            overflow_reg    <= overflow_next;
        end
    end

    // Debounce FSM: a press is accepted after the code has been stable for
    // DEBOUNCE_CYCLES further samples; release needs the same quiet time.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        code_next  = code_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (kp.key_hit) begin
                    state_next = DB_PRESS;
                    code_next  = kp.key_raw;
                    cnt_next   = '0;
                end
            end
            DB_PRESS: begin
                if (!kp.key_hit) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (kp.key_raw != code_reg) begin
                    code_next = kp.key_raw;
                    cnt_next  = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    accept     = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            PRESSED: begin
                // Code changes while held are ignored: no auto-repeat.
                if (!kp.key_hit) begin
                    state_next = DB_RELEASE;
                    cnt_next   = '0;
                end
            end
            DB_RELEASE: begin
                if (kp.key_hit) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Entry assembly acts on the same edge that raises key_valid, so the
    // entry outputs already reflect the key during the key_valid cycle.
    always_comb begin
        key_valid_next   = accept;
        key_code_next    = key_code_reg;
        entry_next       = entry_reg;
        count_next       = count_reg;
        entry_value_next = entry_value_reg;
        entry_done_next  = 1'b0;
        overflow_next    = overflow_reg;
        if (accept) begin
            key_code_next = code_reg;
            if (code_reg == 4'hE) begin
                entry_next    = '0;
                count_next    = '0;
                overflow_next = 1'b0;
            end else if (code_reg == 4'hF) begin
                entry_value_next = entry_reg;
                entry_done_next  = 1'b1;
                entry_next       = '0;
                count_next       = '0;
                overflow_next    = 1'b0;
            end else if (count_reg < 3'd4) begin
                entry_next = entry_shifted;
                count_next = count_reg + 3'd1;
            end else begin
                overflow_next = 1'b1;
            end
        end
    end

    assign kp.key_code    = key_code_reg;
    assign kp.key_valid   = key_valid_reg;
    assign kp.entry       = entry_reg;
    assign kp.digit_count = count_reg;
    assign kp.entry_value = entry_value_reg;
    assign kp.entry_done  = entry_done_reg;
    assign kp.overflow    = overflow_reg;

endmodule
